s2mm_packetizer: RTL



---
 rtl/s2mm_packetizer_pkg.sv | 21 ++
 rtl/s2mm_packetizer_if.sv | 15 +
 rtl/s2mm_packetizer_fifo.sv | 62 ++++++
 rtl/s2mm_packetizer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/s2mm_packetizer_pkg.sv
// Shared types and defaults for the S2MM packetizer: FSM states, default widths
// and the saturating drop-counter helper.
package s2mm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 16;
  localparam int DEF_FIFO_DEPTH = 512;
  localparam int OVF_CNT_W      = 16;
  localparam int PKT_CNT_W      = 32;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == {OVF_CNT_W{1'b1}}) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/s2mm_packetizer_if.sv
// AXI4-Stream bundle between the packetizer and the DMA S2MM channel.
interface s2mm_axis_if
  import s2mm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/s2mm_packetizer_fifo.sv
// Synchronous FIFO with a registered read port. A slot is only freed when the
// word has left the output stage, so the whole path holds at most DEPTH words.
module s2mm_sync_fifo
  import s2mm_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             axiclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             free_en,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      free_ptr_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (wr_ptr_r[AW] != free_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == free_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign rd_data = rd_data_r;

  // Storage array, no reset needed since the pointers define validity.
  always_ff @(posedge axiclk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered read data.
  always_ff @(posedge axiclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      free_ptr_r <= {(AW+1){1'b0}};
      rd_data_r  <= {WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + (AW+1)'(1);
        rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
      end
      if (free_en) begin
        free_ptr_r <= free_ptr_r + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/s2mm_packetizer.sv
// Sample stream to fixed-length AXI4-Stream packets: capture FSM, drop/packet
// counters, FIFO and a one-entry output register driving the stream.
module s2mm_packetizer
  import s2mm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 axiclk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_sync_pulse,
  input  logic [LEN_W-1:0]     i_dma_len,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_data_valid,
  s2mm_axis_if.master          m_axis,
  output logic                 o_busy,
  output logic [OVF_CNT_W-1:0] o_ovf_cnt,
  output logic [PKT_CNT_W-1:0] o_pkt_cnt
);
  state_e               state_r, state_s;
  logic [LEN_W-1:0]     len_r, wcnt_r, len_eff_s, wcnt_eff_s;
  logic                 start_s, cap_s, last_s, wr_en_s, drop_s;
  logic                 full_s, empty_s, rd_en_s, out_ready_s, hs_s;
  logic [DATA_W:0]      rd_data_s;
  logic                 s1_valid_r;
  logic                 tvalid_r, tlast_r;
  logic [DATA_W-1:0]    tdata_r;
  logic [DATA_W/8-1:0]  tkeep_r;
  logic                 busy_r;
  logic [OVF_CNT_W-1:0] ovf_r;
  logic [PKT_CNT_W-1:0] pkt_r;

  // Capture qualifiers; the start cycle already uses the new length and a zero count.
  always_comb begin
    start_s    = 1'b0;
    cap_s      = 1'b0;
    len_eff_s  = len_r;
    wcnt_eff_s = wcnt_r;
    case (state_r)
      IDLE: begin
        start_s    = i_sync_pulse & i_en & (i_dma_len != {LEN_W{1'b0}});
        cap_s      = start_s;
        len_eff_s  = start_s ? i_dma_len : len_r;
        wcnt_eff_s = start_s ? {LEN_W{1'b0}} : wcnt_r;
      end
      CAPTURE: cap_s = 1'b1;
      DRAIN:   cap_s = 1'b0;
      default: cap_s = 1'b0;
    endcase
  end

  assign last_s      = (wcnt_eff_s == len_eff_s - LEN_W'(1));
  assign wr_en_s     = cap_s & i_data_valid & ~full_s;
  assign drop_s      = cap_s & i_data_valid & full_s;
  assign out_ready_s = ~tvalid_r | m_axis.tready;
  assign hs_s        = tvalid_r & m_axis.tready;
  assign rd_en_s     = ~empty_s & (~s1_valid_r | out_ready_s);

  // Next-state logic.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE:    state_s = start_s ? ((wr_en_s & last_s) ? DRAIN : CAPTURE) : IDLE;
      CAPTURE: state_s = (wr_en_s & last_s) ? DRAIN : CAPTURE;
      DRAIN:   state_s = (hs_s & tlast_r) ? IDLE : DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axiclk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Packet length, write count, status counters and busy flag.
  always_ff @(posedge axiclk or posedge rst) begin
    if (rst) begin
      len_r  <= {LEN_W{1'b0}};
      wcnt_r <= {LEN_W{1'b0}};
      busy_r <= 1'b0;
      ovf_r  <= {OVF_CNT_W{1'b0}};
      pkt_r  <= {PKT_CNT_W{1'b0}};
    end else begin
      if (start_s) begin
        len_r <= i_dma_len;
      end
      if (wr_en_s) begin
        wcnt_r <= wcnt_eff_s + LEN_W'(1);
      end else if (start_s) begin
        wcnt_r <= {LEN_W{1'b0}};
      end
      busy_r <= (state_r != IDLE);
      if (drop_s) begin
        ovf_r <= sat_inc(ovf_r);
      end
      if (hs_s && tlast_r && (state_r == DRAIN)) begin
        pkt_r <= pkt_r + PKT_CNT_W'(1);
      end
    end
  end

  s2mm_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .axiclk  (axiclk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data ({last_s, i_data}),
    .rd_en   (rd_en_s),
    .rd_data (rd_data_s),
    .free_en (hs_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // FIFO read-data valid flag and the output register it feeds.
  always_ff @(posedge axiclk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      tdata_r    <= {DATA_W{1'b0}};
      tkeep_r    <= {(DATA_W/8){1'b0}};
    end else begin
      s1_valid_r <= rd_en_s ? 1'b1 : (out_ready_s ? 1'b0 : s1_valid_r);
      if (out_ready_s) begin
        tvalid_r <= s1_valid_r;
        tkeep_r  <= s1_valid_r ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
        if (s1_valid_r) begin
          tlast_r <= rd_data_s[DATA_W];
          tdata_r <= rd_data_s[DATA_W-1:0];
        end
      end
    end
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tkeep  = tkeep_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tvalid = tvalid_r;
  assign o_busy        = busy_r;
  assign o_ovf_cnt     = ovf_r;
  assign o_pkt_cnt     = pkt_r;
endmodule
